// File: rtl/asymfifo_pop_ctrl_if.sv
// Handshake bundle between the asymmetric FIFO, the pop controller and the
// downstream consumer. pop_count exists only with ASYMFIFO_POP_CNT_EN.
interface asymfifo_pop_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data_out;
  logic                  fifo_error;
  logic                  fifo_pop_req_n;
  logic                  fifo_flush_n;
  logic                  flush_req;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  err_sticky;
`ifdef ASYMFIFO_POP_CNT_EN
  logic [15:0]           pop_count;
`endif

  // Pop controller side
  modport master (
    input  fifo_empty, fifo_data_out, fifo_error, flush_req, out_ready,
    output fifo_pop_req_n, fifo_flush_n, out_valid, out_data, err_sticky
`ifdef ASYMFIFO_POP_CNT_EN
    , output pop_count
`endif
  );

  // FIFO / control plane / consumer side
  modport slave (
    output fifo_empty, fifo_data_out, fifo_error, flush_req, out_ready,
    input  fifo_pop_req_n, fifo_flush_n, out_valid, out_data, err_sticky
`ifdef ASYMFIFO_POP_CNT_EN
    , input pop_count
`endif
  );
endinterface

// File: rtl/asymfifo_pop_ctrl.sv
// Drain stage for the asymmetric FIFO: issues active-low pops while the FIFO
// holds a word and the 2-entry skid buffer has room, presents words on a
// valid/ready stream, forwards flush and latches the FIFO error flag.
// Optional popped-word counter: define ASYMFIFO_POP_CNT_EN.
module asymfifo_pop_ctrl #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  asymfifo_pop_ctrl_if.master   bus
);

  logic [DATA_WIDTH-1:0] entry [2];
  logic [1:0]            cnt;
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic                  err_q;
  logic                  take;
  logic                  pop;

  // Handshake events and combinational FIFO-facing requests
  always_comb begin
    take = (cnt != 2'd0) & bus.out_ready;
    pop  = ~bus.fifo_empty & ~bus.flush_req & ~rst & ((cnt < 2'd2) | take);
    bus.fifo_pop_req_n = ~pop;
    bus.fifo_flush_n   = ~(bus.flush_req & ~rst);
    bus.out_valid      = (cnt != 2'd0);
    bus.out_data       = entry[rd_ptr];
    bus.err_sticky     = err_q;
  end

  // Skid buffer storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) entry[i] <= '0;
      cnt    <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else if (bus.flush_req) begin
      // a concurrent take is seen by the consumer but not tracked here
      cnt    <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (pop) begin
        entry[wr_ptr] <= bus.fifo_data_out;
        wr_ptr        <= ~wr_ptr;
      end
      if (take) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, pop} - {1'b0, take};
    end
  end

  // Sticky error, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_q | bus.fifo_error;
  end

`ifdef ASYMFIFO_POP_CNT_EN
  logic [15:0] pop_cnt_q;

  // Popped-word counter, wraps naturally at 16 bits
  always_ff @(posedge clk) begin
    if (rst || bus.flush_req) pop_cnt_q <= '0;
    else if (pop)             pop_cnt_q <= pop_cnt_q + 16'd1;
  end

  // Counter output
  always_comb bus.pop_count = pop_cnt_q;
`endif

endmodule

// File: tb/tb_asymfifo_pop_ctrl.sv
// Directed bench for asymfifo_pop_ctrl with a queue-based FIFO model.
module tb_asymfifo_pop_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  asymfifo_pop_ctrl_if #(.DATA_WIDTH(16)) bus ();
  asymfifo_pop_ctrl #(.DATA_WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [15:0] q   [$];
  logic [15:0] got [$];
  int n_checks = 0;
  int n_fail   = 0;
  int npops    = 0;
  bit src_inf  = 0;

  task automatic drive_fifo();
    if (src_inf) begin
      bus.fifo_empty    = 1'b0;
      bus.fifo_data_out = 16'h5A5A;
    end else begin
      bus.fifo_empty    = (q.size() == 0);
      bus.fifo_data_out = (q.size() == 0) ? 16'h0000 : q[0];
    end
  endtask

  // One clock: sample pop/take before the edge, update FIFO model after it
  task automatic tick();
    logic p;
    #1;
    p = ~bus.fifo_pop_req_n;
    if (bus.out_valid && bus.out_ready && !bus.flush_req) got.push_back(bus.out_data);
    @(posedge clk);
    if (p) begin
      npops++;
      if (!src_inf && q.size() > 0) void'(q.pop_front());
    end
    #1;
    drive_fifo();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.flush_req = 1'b1; bus.out_ready = 1'b1; bus.fifo_error = 1'b0;
    q = '{16'hDEAD}; drive_fifo();
    #1;
    n_checks++; if (bus.fifo_pop_req_n !== 1'b1) begin n_fail++; $display("FAIL rst_pop_n: got %b want 1", bus.fifo_pop_req_n); end
    n_checks++; if (bus.fifo_flush_n !== 1'b1) begin n_fail++; $display("FAIL rst_flush_n: got %b want 1", bus.fifo_flush_n); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.out_data !== 16'h0000) begin n_fail++; $display("FAIL rst_data: got %h want 0000", bus.out_data); end
    n_checks++; if (bus.err_sticky !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", bus.err_sticky); end
`ifdef ASYMFIFO_POP_CNT_EN
    n_checks++; if (bus.pop_count !== 16'd0) begin n_fail++; $display("FAIL rst_popcnt: got %0d want 0", bus.pop_count); end
`endif
    rst = 1'b0; bus.flush_req = 1'b0; q.delete(); drive_fifo();
    tick();
  endtask

  task automatic test_latency();
    got.delete();
    q = '{16'h1234}; drive_fifo(); bus.out_ready = 1'b1;
    #1;
    n_checks++; if (bus.fifo_pop_req_n !== 1'b0) begin n_fail++; $display("FAIL lat_pop_n: got %b want 0", bus.fifo_pop_req_n); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL lat_valid: got %b want 1", bus.out_valid); end
    n_checks++; if (bus.out_data !== 16'h1234) begin n_fail++; $display("FAIL lat_data: got %h want 1234", bus.out_data); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_stall();
    got.delete(); npops = 0;
    bus.out_ready = 1'b0;
    q = '{16'hA001, 16'hA002, 16'hA003}; drive_fifo();
    for (int i = 0; i < 3; i++) tick();
    n_checks++; if (npops !== 2) begin n_fail++; $display("FAIL stall_pops: got %0d want 2", npops); end
    n_checks++; if (bus.fifo_pop_req_n !== 1'b1) begin n_fail++; $display("FAIL stall_pop_n: got %b want 1", bus.fifo_pop_req_n); end
    n_checks++; if (bus.out_data !== 16'hA001) begin n_fail++; $display("FAIL stall_hold: got %h want a001", bus.out_data); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (got.size() !== i + 1) begin n_fail++; $display("FAIL stall_gap: got %0d words want %0d", got.size(), i + 1); end
    end
    for (int i = 0; i < 3; i++) begin
      logic [15:0] exp;
      exp = 16'hA001 + 16'(i);
      n_checks++; if (got.size() <= i || got[i] !== exp) begin n_fail++; $display("FAIL stall_order[%0d]: got %h want %h", i, (got.size() > i) ? got[i] : 16'hxxxx, exp); end
    end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_empty: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_stream();
    got.delete();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) q.push_back(16'(i));
    drive_fifo();
    for (int i = 0; i < 9; i++) begin
      tick();
      n_checks++; if (dut.cnt > 2'd1) begin n_fail++; $display("FAIL stream_cnt: got %0d want <=1", dut.cnt); end
      if (i < 8) begin
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b want 1", i, bus.out_valid); end
      end
    end
    n_checks++; if (got.size() !== 8) begin n_fail++; $display("FAIL stream_len: got %0d want 8", got.size()); end
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (got.size() <= i || got[i] !== 16'(i)) begin n_fail++; $display("FAIL stream_word[%0d]: got %h want %h", i, (got.size() > i) ? got[i] : 16'hxxxx, 16'(i)); end
    end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    q = '{16'hB001, 16'hB002, 16'hB003}; drive_fifo();
    tick(); tick();
    n_checks++; if (dut.cnt !== 2'd2) begin n_fail++; $display("FAIL flush_pre_cnt: got %0d want 2", dut.cnt); end
`ifdef ASYMFIFO_POP_CNT_EN
    n_checks++; if (bus.pop_count !== 16'd14) begin n_fail++; $display("FAIL flush_pre_popcnt: got %0d want 14", bus.pop_count); end
`endif
    bus.flush_req = 1'b1;
    #1;
    n_checks++; if (bus.fifo_flush_n !== 1'b0) begin n_fail++; $display("FAIL flush_n: got %b want 0", bus.fifo_flush_n); end
    n_checks++; if (bus.fifo_pop_req_n !== 1'b1) begin n_fail++; $display("FAIL flush_nopop: got %b want 1", bus.fifo_pop_req_n); end
    tick();
    bus.flush_req = 1'b0; q.delete(); drive_fifo();
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", bus.out_valid); end
`ifdef ASYMFIFO_POP_CNT_EN
    n_checks++; if (bus.pop_count !== 16'd0) begin n_fail++; $display("FAIL flush_popcnt: got %0d want 0", bus.pop_count); end
`endif
    tick();
  endtask

  task automatic test_error();
    n_checks++; if (bus.err_sticky !== 1'b0) begin n_fail++; $display("FAIL err_pre: got %b want 0", bus.err_sticky); end
    bus.fifo_error = 1'b1; tick(); bus.fifo_error = 1'b0; tick();
    n_checks++; if (bus.err_sticky !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b want 1", bus.err_sticky); end
    bus.flush_req = 1'b1; tick(); bus.flush_req = 1'b0; tick();
    n_checks++; if (bus.err_sticky !== 1'b1) begin n_fail++; $display("FAIL err_flush: got %b want 1", bus.err_sticky); end
    rst = 1'b1; tick(); rst = 1'b0; tick();
    n_checks++; if (bus.err_sticky !== 1'b0) begin n_fail++; $display("FAIL err_rst: got %b want 0", bus.err_sticky); end
  endtask

`ifdef ASYMFIFO_POP_CNT_EN
  task automatic test_wrap();
    rst = 1'b1; tick(); rst = 1'b0;
    bus.out_ready = 1'b1; src_inf = 1'b1; drive_fifo();
    for (int i = 0; i < 65537; i++) tick();
    src_inf = 1'b0; q.delete(); drive_fifo();
    #1;
    n_checks++; if (bus.pop_count !== 16'd1) begin n_fail++; $display("FAIL wrap_popcnt: got %0d want 1", bus.pop_count); end
  endtask
`endif

  initial begin
    bus.fifo_empty = 1'b1; bus.fifo_data_out = '0; bus.fifo_error = 1'b0;
    bus.flush_req = 1'b0; bus.out_ready = 1'b0;
    test_reset();
    test_latency();
    test_stall();
    test_stream();
    test_flush();
    test_error();
`ifdef ASYMFIFO_POP_CNT_EN
    test_wrap();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/asymfifo_pop_ctrl.md
# asymfifo_pop_ctrl

Downstream drain stage for the single-clock asymmetric FIFO (8-bit push, 16-bit pop). It issues active-low pop requests whenever the FIFO holds a full output word and local space exists. Popped words are presented on a valid/ready stream through a 2-entry skid buffer, so the downstream consumer may stall without losing data. It also forwards a flush request to the FIFO and latches the FIFO's error flag.

## Interface
- `DATA_WIDTH`, 16: FIFO output word width; equals the FIFO's `data_out_width`.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `fifo_empty` input 1: FIFO empty flag; head word on `fifo_data_out` is valid when 0.
- `fifo_data_out` input DATA_WIDTH: FIFO head word (combinational, show-ahead).
- `fifo_error` input 1: FIFO error flag.
- `fifo_pop_req_n` output 1: active-low pop request to the FIFO.
- `fifo_flush_n` output 1: active-low flush request to the FIFO.
- `flush_req` input 1: active-high flush command from the control plane.
- `out_valid` output 1: output word available.
- `out_ready` input 1: consumer accepts the word when it is high together with `out_valid`.
- `out_data` output DATA_WIDTH: output word.
- `err_sticky` output 1: latched FIFO error.
- `pop_count` output 16: popped-word counter; present only with `ASYMFIFO_POP_CNT_EN`.

## Operation
- Buffer: 2 entries, a 2-bit occupancy `cnt` (0..2), and a 1-bit head pointer `rd_ptr` with a 1-bit tail pointer `wr_ptr`.
- Output signals:
  - `out_valid = (cnt != 0)`.
  - `out_data = entry[rd_ptr]`.
- Events:
  - `take = out_valid & out_ready`.
  - `pop = ~fifo_empty & ~flush_req & ~rst & ((cnt < 2) | take)`.
- `fifo_pop_req_n = ~pop`. This path is combinational from `fifo_empty`, `out_ready`, `flush_req` and `rst`.
- On a pop edge:
  - `entry[wr_ptr] <= fifo_data_out`.
  - `wr_ptr` toggles.
- On a take edge, `rd_ptr` toggles.
- Occupancy update: `cnt <= cnt + pop - take`. Simultaneous pop and take at `cnt` = 2 or 1 leaves `cnt` unchanged. Pointers wrap modulo 2.
- Flush:
  - `fifo_flush_n = ~(flush_req & ~rst)`.
  - On an edge with `flush_req` = 1, `cnt`, `rd_ptr` and `wr_ptr` clear to 0 and no pop is issued.
  - A take in the same cycle is honoured by the consumer but discarded internally.
- Error: `err_sticky <= err_sticky | fifo_error`. It is cleared only by `rst`; flush does not clear it.
- Stream rule: while `out_valid` = 1 and `take` = 0, `out_data` holds stable.

## Timing
- Reset values at the first edge with `rst` = 1:
  - `out_valid` 0 and `out_data` 0. Entries are cleared.
  - `cnt`, `rd_ptr`, `wr_ptr` are 0.
  - `err_sticky` 0 and `pop_count` 0.
- While `rst` is high, `fifo_pop_req_n` = 1 and `fifo_flush_n` = 1.
- Latency from FIFO non-empty to `out_valid`:
  - The pop is asserted in the same cycle that `fifo_empty` = 0.
  - `out_valid` rises on the next edge, giving 1 cycle.
- Throughput: 1 word/cycle sustained when `out_ready` is held high.
- Stall: with `out_ready` = 0, at most 2 words are popped, then `fifo_pop_req_n` stays 1.
- Reset mid-operation: buffered words are dropped, the FIFO is not popped during reset, and no flush is issued.

## Configuration
- `ASYMFIFO_POP_CNT_EN` defined:
  - The `pop_count` port exists.
  - It increments by 1 on every pop edge and wraps from 0xFFFF to 0.
  - It clears on `rst` and on `flush_req`.
- `ASYMFIFO_POP_CNT_EN` undefined:
  - The port and counter logic are absent.
  - All other behaviour is identical.

## Test plan
- Reset, then FIFO non-empty with head 0x1234 and `out_ready` = 1:
  - `fifo_pop_req_n` = 0 in that cycle.
  - `out_valid` = 1 with `out_data` = 0x1234 one cycle later.
- Stall: `out_ready` = 0 with 3 words 0xA001..0xA003 in the FIFO:
  - Exactly 2 pops occur, then `fifo_pop_req_n` stays 1.
  - Raising `out_ready` delivers 0xA001, 0xA002, 0xA003 in order with no gaps.
- Streaming: `out_ready` = 1 with 8 consecutive words 0x0000..0x0007:
  - One word per cycle, in order, with `cnt` never exceeding 1.
- Flush: `cnt` = 2 and `flush_req` pulsed for 1 cycle:
  - `fifo_flush_n` = 0 in that cycle and no pop is issued.
  - `out_valid` = 0 on the next edge.
  - With `ASYMFIFO_POP_CNT_EN` defined, `pop_count` = 0 on the next edge.
- Error: pulse `fifo_error` for 1 cycle, then pulse `flush_req`:
  - `err_sticky` = 1 and stays 1 after the flush.
  - `err_sticky` returns to 0 only after `rst`.
- Counter wrap, with `ASYMFIFO_POP_CNT_EN` defined: 65537 pops yield `pop_count` = 1.
